// File: rtl/dm_axi_master_pkg.sv
// Shared AXI4 encodings and bus widths used by the data-memory master,
// the interconnect and the slaves.
package dm_axi_master_pkg;

    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10
    } axi_burst_e;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExOkay = 2'b01,
        RespSlvErr = 2'b10,
        RespDecErr = 2'b11
    } axi_resp_e;

    // Single-beat word transfers only.
    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

endpackage

// File: rtl/dm_axi_master_if.sv
// AXI4 bus between the data-memory master and the interconnect.
interface dm_axi_master_if;
    import dm_axi_master_pkg::*;

    // Read address channel
    logic [AXI_ID_W-1:0]   ARID;
    logic [AXI_ADDR_W-1:0] ARADDR;
    logic [3:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;
    logic                  ARVALID;
    logic                  ARREADY;
    // Read data channel
    logic [AXI_ID_W-1:0]   RID;
    logic [AXI_DATA_W-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;
    // Write address channel
    logic [AXI_ID_W-1:0]   AWID;
    logic [AXI_ADDR_W-1:0] AWADDR;
    logic [3:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;
    // Write data channel
    logic [AXI_DATA_W-1:0] WDATA;
    logic [AXI_STRB_W-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    // Write response channel
    logic [AXI_ID_W-1:0]   BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

endinterface

// File: rtl/dm_axi_master.sv
// Data-memory AXI4 master: turns MEM-stage loads/stores into single-beat
// AXI transactions and stalls the pipeline with DM_busy until each completes.
module dm_axi_master
    import dm_axi_master_pkg::*;
#(
    parameter logic [AXI_ID_W-1:0] MASTER_ID = 4'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [AXI_ADDR_W-1:0] req_addr,
    input  logic [AXI_DATA_W-1:0] req_wdata,
    input  logic [AXI_STRB_W-1:0] req_wstrb,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic                  DM_busy,
    dm_axi_master_if.master       bus
);

    typedef enum logic [2:0] {
        StIdle, StRaddr, StRdata, StWreq, StWresp, StDone
    } state_e;

    state_e                state_q;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [AXI_DATA_W-1:0] wdata_q;
    logic [AXI_STRB_W-1:0] wstrb_q;
    logic [AXI_DATA_W-1:0] rdata_q;
    logic                  arvalid_q, awvalid_q, wvalid_q, rready_q, bready_q;
    logic                  aw_done_q, w_done_q;
    logic                  aw_hs, w_hs, aw_done_d, w_done_d;

    // Response codes and IDs are deliberately ignored.
    logic unused_resp;
    assign unused_resp = ^{bus.RID, bus.RRESP, bus.BID, bus.BRESP};

    // Write-channel handshakes this cycle and the sticky completion they imply.
    always_comb begin
        aw_hs     = awvalid_q & bus.AWREADY;
        w_hs      = wvalid_q & bus.WREADY;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
    end

    // Transaction FSM; every bus valid/ready is a register driven from here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Loads win when both requests are present.
                    if (req_read) begin
                        addr_q    <= req_addr;
                        arvalid_q <= 1'b1;
                        state_q   <= StRaddr;
                    end else if (req_write) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= StWreq;
                    end
                end
                StRaddr: begin
                    if (bus.ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdata;
                    end
                end
                StRdata: begin
                    if (bus.RVALID && bus.RLAST) begin
                        rdata_q  <= bus.RDATA;
                        rready_q <= 1'b0;
                        state_q  <= StDone;
                    end
                end
                StWreq: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= StWresp;
                    end else begin
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                    end
                end
                StWresp: begin
                    if (bus.BVALID) begin
                        bready_q <= 1'b0;
                        state_q  <= StDone;
                    end
                end
                // The request still visible here is the one just completed.
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Stall from the first idle cycle with a request until the DONE cycle.
    always_comb begin
        case (state_q)
            StIdle:                            DM_busy = ~rst & (req_read | req_write);
            StRaddr, StRdata, StWreq, StWresp: DM_busy = ~rst;
            default:                           DM_busy = 1'b0;
        endcase
    end

    assign rdata       = rdata_q;

    assign bus.ARID    = MASTER_ID;
    assign bus.ARADDR  = addr_q;
    assign bus.ARLEN   = AXI_LEN_SINGLE;
    assign bus.ARSIZE  = AXI_SIZE_WORD;
    assign bus.ARBURST = BurstIncr;
    assign bus.ARVALID = arvalid_q;
    assign bus.RREADY  = rready_q;

    assign bus.AWID    = MASTER_ID;
    assign bus.AWADDR  = addr_q;
    assign bus.AWLEN   = AXI_LEN_SINGLE;
    assign bus.AWSIZE  = AXI_SIZE_WORD;
    assign bus.AWBURST = BurstIncr;
    assign bus.AWVALID = awvalid_q;
    assign bus.WDATA   = wdata_q;
    assign bus.WSTRB   = wstrb_q;
    assign bus.WLAST   = wvalid_q;
    assign bus.WVALID  = wvalid_q;
    assign bus.BREADY  = bready_q;

endmodule

// File: doc/dm_axi_master.md
# dm_axi_master

CPU-side data-memory bus master. It takes load/store requests from the MEM stage, runs single-beat AXI4 read or write transactions, and drives `DM_busy`. That signal freezes the upstream pipeline registers, including ID/EX, until the transaction finishes. It sits between the MEM stage and the AXI interconnect, opposite the slave port that serves DM.

## Interface
Parameters:
- `MASTER_ID`, default 4'd1: value driven on ARID/AWID.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_read`  in  1  MEM-stage load request (MemRead).
- `req_write`  in  1  MEM-stage store request (MemWrite).
- `req_addr`  in  32  byte address (ALU result).
- `req_wdata`  in  32  store data, already lane-aligned.
- `req_wstrb`  in  4  store byte enables, active-high.
- `rdata`  out  32  last completed load data.
- `DM_busy`  out  1  stall request to all pipeline registers.
- `ARID`/`AWID`  out  4  = MASTER_ID.
- `ARADDR`/`AWADDR`  out  32  registered req_addr.
- `ARLEN`/`AWLEN`, `ARSIZE`/`AWSIZE`, `ARBURST`/`AWBURST`  out  4/3/2  constants 0, 3'b010, 2'b01 (single word, INCR).
- `ARVALID`, `AWVALID`, `WVALID`  out  1  channel valids.
- `ARREADY`, `AWREADY`, `WREADY`  in  1  channel readies.
- `WDATA`  out  32, `WSTRB`  out  4, `WLAST`  out  1 (=1 whenever WVALID).
- `RID`  in  4, `RDATA`  in  32, `RRESP`  in  2, `RLAST`  in  1, `RVALID`  in  1, `RREADY`  out  1.
- `BID`  in  4, `BRESP`  in  2, `BVALID`  in  1, `BREADY`  out  1.

## Operation
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- Request capture:
  - In IDLE, `req_read` → RADDR; address is latched.
  - In IDLE, `req_write` → WREQ; address, data and strobe are latched.
  - If both are asserted, read wins.
- RADDR: ARVALID=1 until ARREADY, then → RDATA.
- RDATA: RREADY=1; on RVALID&RLAST, latch RDATA into `rdata` and → DONE.
- WREQ:
  - AWVALID and WVALID are raised in the same cycle.
  - Sticky flags `aw_done`/`w_done` drop each valid independently on its handshake.
  - When both are done (same cycle allowed) → WRESP; flags clear.
- WRESP: BREADY=1; on BVALID → DONE.
- DONE: unconditional → IDLE. The request still present in this cycle belongs to the completed instruction and does not retrigger.
- `DM_busy` is combinational: 1 when (IDLE & (req_read|req_write)) or state ∈ {RADDR, RDATA, WREQ, WRESP}; 0 in DONE and in idle with no request.
- Valids never drop before their handshake. Addr/data/strobe are stable while the valid is high.
- RRESP/BRESP non-OKAY: not reported; the transaction completes normally. RID/BID are not checked.

## Timing
- Reset: state=IDLE, all VALID/READY outputs 0, ARADDR/AWADDR/WDATA=0, WSTRB=0, `rdata`=0, `DM_busy`=0, flags 0.
- Reset mid-transaction: same values immediately, with no handshake completion. The slave is assumed reset together.
- Zero-wait slave:
  - load: `DM_busy` high 3 cycles (IDLE, RADDR, RDATA); `rdata` valid from the DONE cycle on.
  - store: high 3 cycles (IDLE, WREQ, WRESP).
- `rdata` holds its value until the next load completes; stores do not alter it.
- Back-to-back memory instructions: minimum one non-busy (DONE) cycle between them.

## Structure
- A shared AXI package holds the burst/size/resp encodings and the ID width, used by the interconnect and slaves.
- The FSM state enum is local to the module.
- No sub-module; single module.

## Test plan
- Load, slave with ARREADY/RVALID same cycle, RDATA=32'hDEADBEEF → `DM_busy` 1,1,1 then 0; `rdata`=32'hDEADBEEF in DONE.
- Store addr 32'h0000_1004, data 32'h12345678, wstrb 4'b0011; AWREADY in cycle 1, WREADY delayed 3 cycles → AWVALID drops after cycle 1; WVALID holds until WREADY; one B handshake; busy drops after BVALID.
- Load with ARREADY delayed 5 cycles and RVALID delayed 2 → ARVALID/ARADDR stable throughout; `DM_busy` high 1+6+3 cycles.
- req_read and req_write both high → read transaction only; no AWVALID.
- Reset pulse while in RDATA → all valids/readies 0 and `DM_busy`=0 asynchronously. The next load after release completes correctly.
- Store followed by load with `rdata`=32'hA5A5A5A5 beforehand → `rdata` unchanged through the store; it updates only at the load's DONE.
